// File: rtl/im_loader_if.sv
// im_loader_if
// Bundles the two buses of the instruction memory loader:
//   - byte stream : byte_in / byte_valid from the source, byte_ready back
//   - IM write    : im_wr_addr / im_wr_data / im_we towards instruction memory
// Modports:
//   slave  - the loader's view (consumes the byte stream, drives the IM write port)
//   master - the environment's view (drives the byte stream, observes the IM write port)
interface im_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] im_wr_addr;
    logic [DATA_W-1:0] im_wr_data;
    logic              im_we;

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output im_wr_addr,
        output im_wr_data,
        output im_we
    );

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  im_wr_addr,
        input  im_wr_data,
        input  im_we
    );
endinterface

// File: rtl/im_loader.sv
// im_loader
// Program loader for the SISC instruction memory. Receives a byte stream,
// packs every four bytes big-endian into a 32-bit instruction and writes it
// to instruction memory at sequential word addresses starting at 0. The
// processor is held in reset (cpu_rst_f low) while a load is in progress.
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   start        - one-cycle load request, honoured only in IDLE or DONE
//   word_count   - number of words to load, captured on an accepted start
//   bus (slave)  - byte stream handshake and instruction memory write port
//   busy         - load in progress
//   done         - load finished, held until the next accepted start
//   err          - checksum mismatch, held with done
//   cpu_rst_f    - active-low processor reset
// Optional feature macro: IM_LOADER_CHECKSUM_EN
//   When defined, one extra check byte follows the last word and is compared
//   with the XOR of all data bytes of the load; when undefined err is tied 0.
module im_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    im_loader_if.slave        bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_f
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef IM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] target;
    logic              accept;
    logic              start_ok;
    logic              last_word;
    logic              err_next;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
    logic              err_q;
`endif

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    // The address register doubles as the count of words already written.
    assign last_word = (bus.im_wr_addr + ADDR_ONE) == target;

    // Next-state decode; err_next is the value err will hold in the next state.
    always_comb begin
        next_state = state;
`ifdef IM_LOADER_CHECKSUM_EN
        err_next   = err_q;
`else
        err_next   = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    err_next   = 1'b0;
                    next_state = (word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept && (byte_idx == 2'd3)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    next_state = CSUM;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = RECV;
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    next_state = DONE;
                    err_next   = (bus.byte_in != csum);
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // State register and registered outputs, all decoded from the next state
    // so they change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.byte_ready <= 1'b0;
            bus.im_we      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cpu_rst_f      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            err_q          <= 1'b0;
`endif
        end else begin
            state          <= next_state;
`ifdef IM_LOADER_CHECKSUM_EN
            bus.byte_ready <= (next_state == RECV) || (next_state == CSUM);
            err_q          <= err_next;
`else
            bus.byte_ready <= (next_state == RECV);
`endif
            bus.im_we      <= (next_state == WRITE);
            busy           <= (next_state != IDLE) && (next_state != DONE);
            done           <= (next_state == DONE);
            cpu_rst_f      <= (next_state == IDLE) || ((next_state == DONE) && !err_next);
        end
    end

    // Datapath: bytes shift in from the bottom so the first byte of a word ends
    // up in [31:24]; the address advances on leaving WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.im_wr_addr <= '0;
            bus.im_wr_data <= '0;
            byte_idx       <= 2'd0;
            target         <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
        end else if (start_ok) begin
            bus.im_wr_addr <= '0;
            byte_idx       <= 2'd0;
            target         <= word_count;
`ifdef IM_LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
        end else if ((state == RECV) && accept) begin
            bus.im_wr_data <= {bus.im_wr_data[DATA_W-9:0], bus.byte_in};
            byte_idx       <= byte_idx + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            csum           <= csum ^ bus.byte_in;
`endif
        end else if (state == WRITE) begin
            bus.im_wr_addr <= bus.im_wr_addr + ADDR_ONE;
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader
// Self-checking bench for im_loader: a table of load vectors, randomized
// loads with random source stalls, and hand-written reset sequences. The
// expected instruction memory writes are computed from the byte stream by
// packing groups of four bytes; the checksum byte is the XOR of the stream.
module tb_im_loader;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_f;

    im_loader_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    im_loader #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_rst_f  (cpu_rst_f)
    );

    typedef struct {
        logic [15:0]      wc;
        logic [2:0][31:0] words;
        int               stall;
        bit               csum_bad;
        logic             exp_done;
        logic             exp_busy;
    } vec_t;

    int          assertions = 0;
    int          failures   = 0;
    logic [7:0]  stim_q[$];
    logic [15:0] got_addr[$];
    logic [31:0] got_data[$];
    vec_t        vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every instruction memory write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            got_addr.push_back(bus.im_wr_addr);
            got_data.push_back(bus.im_wr_data);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".byte_ready"}, bus.byte_ready, 0);
        checkOutput({name, ".im_we"}, bus.im_we, 0);
        checkOutput({name, ".im_wr_addr"}, bus.im_wr_addr, 0);
        checkOutput({name, ".im_wr_data"}, bus.im_wr_data, 0);
        checkOutput({name, ".busy"}, busy, 0);
        checkOutput({name, ".done"}, done, 0);
        checkOutput({name, ".err"}, err, 0);
        checkOutput({name, ".cpu_rst_f"}, cpu_rst_f, 0);
    endtask

    function automatic vec_t mk(input logic [15:0] wc, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input int stall, input bit bad);
        vec_t v;
        v.wc       = wc;
        v.words    = {w2, w1, w0};
        v.stall    = stall;
        v.csum_bad = bad;
        v.exp_done = 1'b1;
        v.exp_busy = 1'b0;
        return v;
    endfunction

    // Runs one load of the bytes in stim_q. stall: 0 always valid, 1 toggling,
    // 2 random (also throws stray start pulses). stop_after >= 0 abandons the
    // load once that many bytes have been accepted.
    task automatic applyStimulus(input string name, input logic [15:0] wc, input int stall,
                                 input bit csum_bad, input int stop_after,
                                 input logic exp_done, input logic exp_busy);
        logic [7:0] stream[$];
        logic [7:0] chk;
        logic       exp_err;
        bit         pending;
        bit         v;
        int         total;
        int         idx;
        int         cyc;
        int         budget;

        stream = stim_q;
        if (CSUM_ON && wc != 0) begin
            chk = 8'h00;
            foreach (stim_q[i]) chk ^= stim_q[i];
            if (csum_bad) chk ^= 8'h01;
            stream.push_back(chk);
        end
        exp_err = CSUM_ON && (wc != 0) && csum_bad;
        total   = stream.size();
        budget  = 20 * total + 40;
        got_addr.delete();
        got_data.delete();

        @(negedge clk);
        start          = 1'b1;
        word_count     = wc;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        word_count = 16'($urandom);
        if (wc != 0) begin
            checkOutput({name, ".start_busy"}, busy, 1);
            checkOutput({name, ".start_ready"}, bus.byte_ready, 1);
            checkOutput({name, ".start_rst_f"}, cpu_rst_f, 0);
        end else begin
            checkOutput({name, ".zero_done"}, done, 1);
            checkOutput({name, ".zero_rst_f"}, cpu_rst_f, 1);
        end

        idx     = 0;
        pending = 1'b0;
        cyc     = 0;
        while (cyc < budget) begin
            if (pending) idx++;
            if (stop_after >= 0 && idx >= stop_after) begin
                bus.byte_valid = 1'b0;
                start          = 1'b0;
                return;
            end
            if (bus.im_we) checkOutput({name, ".ready_in_write"}, bus.byte_ready, 0);
            if (done) break;
            if (idx < total) begin
                case (stall)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                bus.byte_valid = v;
                bus.byte_in    = v ? stream[idx] : 8'($urandom);
                start          = (stall == 2) && ($urandom_range(0, 7) == 0);
            end else begin
                bus.byte_valid = 1'b0;
                start          = 1'b0;
            end
            pending = bus.byte_valid && bus.byte_ready;
            @(negedge clk);
            cyc++;
        end
        bus.byte_valid = 1'b0;
        start          = 1'b0;

        checkOutput({name, ".done"}, done, exp_done);
        checkOutput({name, ".busy"}, busy, exp_busy);
        checkOutput({name, ".err"}, err, exp_err);
        checkOutput({name, ".cpu_rst_f"}, cpu_rst_f, !exp_err);
        checkOutput({name, ".ready_done"}, bus.byte_ready, 0);
        checkOutput({name, ".bytes_used"}, idx, total);
        checkOutput({name, ".write_count"}, got_addr.size(), wc);
        for (int k = 0; k < int'(wc) && k < got_addr.size(); k++) begin
            checkOutput({name, ".addr"}, got_addr[k], k);
            checkOutput({name, ".data"}, got_data[k],
                        {stim_q[4*k], stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3]});
        end
    endtask

    task automatic loadWords(input vec_t vec);
        stim_q.delete();
        for (int k = 0; k < int'(vec.wc); k++) begin
            for (int b = 3; b >= 0; b--) stim_q.push_back(vec.words[k][b*8 +: 8]);
        end
    endtask

    initial begin
        int          n;
        logic [15:0] rwc;

        vecs[0] = mk(16'd2, 32'h10210005, 32'h20000001, 32'h0, 0, 1'b0);
        vecs[1] = mk(16'd2, 32'h10210005, 32'h20000001, 32'h0, 1, 1'b0);
        vecs[2] = mk(16'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        vecs[3] = mk(16'd1, 32'hDEADBEEF, 32'h0, 32'h0, 2, 1'b0);
        vecs[4] = mk(16'd3, $urandom, $urandom, $urandom, 0, 1'b0);
        vecs[5] = mk(16'd1, 32'h01020304, 32'h0, 32'h0, 0, 1'b0);
        vecs[6] = mk(16'd1, 32'h01020304, 32'h0, 32'h0, 0, 1'b1);

        rst            = 1'b0;
        start          = 1'b0;
        word_count     = 16'd0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        #3 rst = 1'b1;
        #1 checkResetValues("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.release_rst_f", cpu_rst_f, 1);
        checkOutput("reset.release_done", done, 0);

        $display("[TB] table-driven loads");
        foreach (vecs[i]) begin
            loadWords(vecs[i]);
            applyStimulus($sformatf("vec%0d", i), vecs[i].wc, vecs[i].stall, vecs[i].csum_bad, -1,
                          vecs[i].exp_done, vecs[i].exp_busy);
        end

        $display("[TB] reset in the middle of a load");
        loadWords(vecs[0]);
        applyStimulus("midrst", 16'd2, 0, 1'b0, 6, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 checkResetValues("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst.release_rst_f", cpu_rst_f, 1);
        repeat (10) @(negedge clk);
        checkOutput("midrst.write_count", got_addr.size(), 1);
        if (got_addr.size() > 0) begin
            checkOutput("midrst.addr0", got_addr[0], 0);
            checkOutput("midrst.data0", got_data[0], 32'h10210005);
        end
        applyStimulus("reload", 16'd2, 1, 1'b0, -1, 1'b1, 1'b0);

        $display("[TB] randomized loads");
        for (int r = 0; r < 8; r++) begin
            rwc = 16'($urandom_range(1, 6));
            n   = 4 * int'(rwc);
            stim_q.delete();
            for (int b = 0; b < n; b++) stim_q.push_back(8'($urandom_range(0, 255)));
            applyStimulus($sformatf("rand%0d", r), rwc, 2, bit'($urandom_range(0, 1)), -1, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/im_loader.md
# im_loader

Program loader for the SISC instruction memory. It receives a byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit instruction. It writes each instruction into instruction memory at sequential word addresses starting at 0x0000. While loading, it holds the processor in reset through an active-low output that drives the processor's `rst_f`; when the load completes, it releases the processor.

## Interface
- `ADDR_W`, 16, instruction memory address width; also the width of the word counter.
- `DATA_W`, 32, instruction width; fixed at 4 bytes.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `word_count`  in  16  number of words to load; captured on an accepted `start`.
- `byte_in`  in  8  stream data byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte.
- `im_wr_addr`  out  16  instruction memory write address.
- `im_wr_data`  out  32  instruction memory write data.
- `im_we`  out  1  instruction memory write strobe, one cycle per word.
- `cpu_rst_f`  out  1  active-low processor reset; low while loading.
- `busy`  out  1  load in progress.
- `done`  out  1  load finished; held until the next accepted `start`.
- `err`  out  1  checksum mismatch; held with `done`.

## Operation
- **States:** IDLE, RECV, WRITE, CSUM, DONE.
- **Byte transfer:** a byte is transferred on a rising edge where `byte_valid && byte_ready`.
- **Outputs are registered.** `byte_ready` is 1 only in RECV and CSUM.
- **IDLE:**
  - `start` with `word_count` ≠ 0 → RECV. Word counter, byte index and address are cleared to 0.
  - `start` with `word_count` = 0 → DONE, with `err` = 0.
- **RECV:** bytes are packed big-endian. The first byte goes to [31:24] (the opcode byte), the fourth to [7:0]. After the 4th byte → WRITE.
- **WRITE:** one cycle.
  - `im_we` = 1 with the current address and the assembled word.
  - Then the address and word counter increment.
  - If the counter equals `word_count` → CSUM when `IM_LOADER_CHECKSUM_EN` is defined, otherwise → DONE.
  - Otherwise → RECV.
- **DONE:** `done` = 1 and `cpu_rst_f` = 1. `start` → new load; `done` and `err` clear.
- **`start` during RECV, WRITE or CSUM** is ignored. `word_count` changes after capture have no effect.
- **Status outputs:**
  - `busy` = 1 in RECV, WRITE and CSUM.
  - `cpu_rst_f` = 0 in RECV, WRITE and CSUM.
  - `cpu_rst_f` = 0 in DONE when `err` = 1.
  - `cpu_rst_f` = 1 in IDLE, and in DONE when `err` = 0.
- **Address range:** addresses run 0x0000 to `word_count`−1. The maximum of 65535 words means the address never wraps.
- **Bytes outside RECV/CSUM** are not accepted (`byte_ready` = 0). The source holds them.

## Timing
- **Reset values:** state IDLE; `byte_ready` 0, `im_we` 0, `im_wr_addr` 0, `im_wr_data` 0, `busy` 0, `done` 0, `err` 0, `cpu_rst_f` 0.
- **After reset release:** `cpu_rst_f` goes to 1 on the first rising edge after `rst` deasserts.
- **Reset mid-load:** all outputs return to reset values immediately (asynchronously). No further `im_we` pulses occur. A partially assembled word is discarded.
- **Start latency:** `start` accepted at edge N gives `busy` = 1, `byte_ready` = 1 and `cpu_rst_f` = 0 after edge N.
- **Write latency:** the 4th byte accepted at edge N gives `im_we` high during cycle N→N+1. `byte_ready` is 0 in that cycle and returns to 1 after edge N+1.
- **Throughput:** at most one word per 5 cycles with a continuously valid stream.
- **Write interface:** `im_wr_addr` and `im_wr_data` are stable for the whole cycle `im_we` is high. Memory commits on the next rising edge.
- **Completion:** `done` rises on the edge that leaves WRITE (or CSUM).

## Configuration
- **`IM_LOADER_CHECKSUM_EN` defined:**
  - After the last WRITE, state CSUM accepts exactly one byte.
  - That byte is compared to the XOR of all data bytes received in this load.
  - On mismatch: `err` = 1 and `cpu_rst_f` stays 0 in DONE.
  - On match: `err` = 0 and `cpu_rst_f` = 1.
  - A load with `word_count` = 0 skips CSUM.
- **Not defined:** the CSUM state and XOR accumulator are absent, `err` is tied 0, and WRITE of the last word → DONE.

## Test plan
- **Reset:** `rst` pulse mid-cycle → all outputs at reset values immediately. `cpu_rst_f` = 1 one edge after release.
- **Two-word load:** `word_count` = 2, bytes 0x10 0x21 0x00 0x05, 0x20 0x00 0x00 0x01 → `im_we` pulses at addr 0x0000 data 0x10210005, then at 0x0001 data 0x20000001. Then `done` = 1, `busy` = 0, `cpu_rst_f` = 1.
- **Zero words:** `start` with `word_count` = 0 → DONE next edge, no `im_we`, `cpu_rst_f` = 1.
- **Stalled source:** `byte_valid` toggling 1/0 every cycle during the two-word load → same writes and data. No byte is lost or duplicated. `byte_ready` = 0 during each WRITE cycle.
- **Reset mid-load:** `rst` asserted after 6 of 8 bytes → second `im_we` never occurs. A following `start` reloads from address 0x0000.
- **Checksum (with `IM_LOADER_CHECKSUM_EN`):** one word 0x01 0x02 0x03 0x04, check byte 0x04 → `err` = 0, `cpu_rst_f` = 1. Check byte 0x05 → `err` = 1, `done` = 1, `cpu_rst_f` = 0.
